// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write port, packed read ports, clear control and status.
interface register_file_mp_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_RD     = 2
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                           clr;
  logic                           busy;
  logic                           w_en;
  logic [ADDR_WIDTH-1:0]          w_addr;
  logic [BE_WIDTH-1:0]            w_be;
  logic [DATA_WIDTH-1:0]          w_data;
  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]   r_data;
  logic [NUM_RD-1:0]              par_err;

  modport master (
    output clr, w_en, w_addr, w_be, w_data, r_addr,
    input  busy, r_data, par_err
  );

  modport slave (
    input  clr, w_en, w_addr, w_be, w_data, r_addr,
    output busy, r_data, par_err
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-enable write, write-first bypass and clear sequencer.
// Optional per-byte even parity storage and checking when RF_PARITY_EN is defined.
module register_file_mp #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  register_file_mp_if.slave  bus
);
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [ADDR_WIDTH-1:0]         r_ptr;
  logic [ADDR_WIDTH-1:0]         w_ptr_nxt;
  logic                          r_busy;
  logic                          w_busy_nxt;
  logic [NUM_RD*DATA_WIDTH-1:0]  r_rd_data;

  logic [DATA_WIDTH-1:0]         r_mem [DEPTH];

  logic                          w_mem_we;
  logic [ADDR_WIDTH-1:0]         w_mem_addr;
  logic [BE_WIDTH-1:0]           w_mem_be;
  logic [DATA_WIDTH-1:0]         w_mem_bits;
  logic [DATA_WIDTH-1:0]         w_mem_data;
  logic [ADDR_WIDTH-1:0]         w_rd_addr;
  logic [DATA_WIDTH-1:0]         w_rd_word;
  logic                          w_rd_hit;
  logic [NUM_RD*DATA_WIDTH-1:0]  w_rd_data;

`ifdef RF_PARITY_EN
  logic [BE_WIDTH-1:0]           r_par [DEPTH];
  logic [BE_WIDTH-1:0]           w_mem_par;
  logic [BE_WIDTH-1:0]           w_rd_par;
  logic [NUM_RD-1:0]             w_rd_perr;
  logic [NUM_RD-1:0]             r_par_err;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_CLEAR;
      r_ptr     <= '0;
      r_busy    <= 1'b1;
      r_rd_data <= '0;
`ifdef RF_PARITY_EN
      r_par_err <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_busy    <= w_busy_nxt;
      r_rd_data <= w_busy_nxt ? '0 : w_rd_data;
`ifdef RF_PARITY_EN
      r_par_err <= w_busy_nxt ? '0 : w_rd_perr;
`endif
    end
  end

  // Clear sequencer next state; clr is only honoured from IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
        if (r_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.clr) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
    w_busy_nxt = (w_state_nxt == ST_CLEAR);
  end

  // Single array write port shared by the clear sweep and user writes
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = bus.w_addr;
    w_mem_be   = bus.w_be;
    w_mem_data = bus.w_data;
    if (r_state == ST_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_ptr;
      w_mem_be   = '1;
      w_mem_data = '0;
    end else if (bus.w_en && (bus.w_be != '0)) begin
      w_mem_we   = 1'b1;
    end
    w_mem_bits = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      w_mem_bits[8*i +: 8] = {8{w_mem_be[i]}};
    end
  end

`ifdef RF_PARITY_EN
  always_comb begin
    w_mem_par = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      w_mem_par[i] = ^w_mem_data[8*i +: 8];
    end
  end
`endif

  // Storage array is intentionally not reset; the clear sweep initialises it
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= (r_mem[w_mem_addr] & ~w_mem_bits) | (w_mem_data & w_mem_bits);
`ifdef RF_PARITY_EN
      r_par[w_mem_addr] <= (r_par[w_mem_addr] & ~w_mem_be) | (w_mem_par & w_mem_be);
`endif
    end
  end

  // Read ports with write-first merge; bypassed reads never flag parity
  always_comb begin
    w_rd_data = '0;
    w_rd_addr = '0;
    w_rd_word = '0;
    w_rd_hit  = 1'b0;
`ifdef RF_PARITY_EN
    w_rd_perr = '0;
    w_rd_par  = '0;
`endif
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      w_rd_addr = bus.r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      w_rd_word = r_mem[w_rd_addr];
      w_rd_hit  = w_mem_we && (w_mem_addr == w_rd_addr);
`ifdef RF_PARITY_EN
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        w_rd_par[i] = ^w_rd_word[8*i +: 8];
      end
      w_rd_perr[k] = !w_rd_hit && ((w_rd_par ^ r_par[w_rd_addr]) != '0);
`endif
      if (w_rd_hit) begin
        w_rd_word = (w_rd_word & ~w_mem_bits) | (w_mem_data & w_mem_bits);
      end
      w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_word;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.r_data = r_rd_data;
`ifdef RF_PARITY_EN
  assign bus.par_err = r_par_err;
`else
  assign bus.par_err = '0;
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp (ADDR_WIDTH=3, DATA_WIDTH=16, NUM_RD=2).
module tb_register_file_mp;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned NR = 2;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  register_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

  register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input int a, input logic [1:0] be, input logic [15:0] d);
    bus.w_en   = 1'b1;
    bus.w_addr = AW'(a);
    bus.w_be   = be;
    bus.w_data = d;
    @(posedge clk); #1;
    bus.w_en   = 1'b0;
  endtask

  task automatic do_read(input int a0, input int a1,
                         output logic [15:0] d0, output logic [15:0] d1, output logic [1:0] pe);
    bus.r_addr = {AW'(a1), AW'(a0)};
    @(posedge clk); #1;
    d0 = bus.r_data[15:0];
    d1 = bus.r_data[31:16];
    pe = bus.par_err;
  endtask

  task automatic fill_all(input logic [15:0] d);
    for (int a = 0; a < 8; a++) do_write(a, 2'b11, d);
  endtask

  task automatic wait_busy_low(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic test_all_zero(input string tag);
    logic [15:0] d0, d1;
    logic [1:0]  pe;
    for (int a = 0; a < 8; a++) begin
      do_read(a, 7 - a, d0, d1, pe);
      total++;
      if (d0 !== 16'h0 || d1 !== 16'h0 || pe !== 2'b00) begin
        bad++;
        $display("FAIL %s addr=%0d: got p0=%h p1=%h perr=%b expected 0000 0000 00", tag, a, d0, d1, pe);
      end
    end
  endtask

  task automatic test_reset;
    int cnt;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    total++;
    if (bus.r_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", bus.r_data); end
    total++;
    if (bus.par_err !== 2'b00) begin bad++; $display("FAIL reset_parerr: got %b expected 00", bus.par_err); end
    reset_n = 1'b1;
    wait_busy_low(cnt);
    total++;
    if (cnt !== 8) begin bad++; $display("FAIL reset_busy_len: got %0d expected 8", cnt); end
    test_all_zero("reset_read");
  endtask

  task automatic test_byte_enable;
    logic [15:0] d0, d1;
    logic [1:0]  pe;
    do_write(5, 2'b11, 16'hABCD);
    do_write(5, 2'b01, 16'h1234);
    do_read(5, 0, d0, d1, pe);
    do_read(5, 5, d0, d1, pe);
    total++;
    if (d0 !== 16'hAB34 || d1 !== 16'hAB34) begin
      bad++; $display("FAIL byte_enable: got %h/%h expected ab34/ab34", d0, d1);
    end
    do_write(5, 2'b00, 16'hFFFF);
    do_read(5, 5, d0, d1, pe);
    total++;
    if (d0 !== 16'hAB34) begin bad++; $display("FAIL be_zero_noop: got %h expected ab34", d0); end
    do_write(5, 2'b10, 16'h5500);
    do_read(5, 0, d0, d1, pe);
    total++;
    if (d0 !== 16'h5534) begin bad++; $display("FAIL be_upper: got %h expected 5534", d0); end
  endtask

  task automatic test_bypass;
    logic [15:0] d0, d1;
    logic [1:0]  pe;
    do_write(2, 2'b11, 16'h0011);
    do_write(3, 2'b11, 16'h0077);
    bus.r_addr = {AW'(3), AW'(2)};
    do_write(2, 2'b11, 16'h005A);
    total++;
    if (bus.r_data[15:0] !== 16'h005A || bus.r_data[31:16] !== 16'h0077) begin
      bad++; $display("FAIL bypass_dual: got %h/%h expected 005a/0077", bus.r_data[15:0], bus.r_data[31:16]);
    end
    bus.r_addr = {AW'(3), AW'(3)};
    do_write(3, 2'b10, 16'hEE00);
    total++;
    if (bus.r_data[15:0] !== 16'hEE77 || bus.r_data[31:16] !== 16'hEE77) begin
      bad++; $display("FAIL bypass_merge: got %h/%h expected ee77/ee77", bus.r_data[15:0], bus.r_data[31:16]);
    end
    do_read(2, 3, d0, d1, pe);
    total++;
    if (d0 !== 16'h005A || d1 !== 16'hEE77) begin
      bad++; $display("FAIL bypass_stored: got %h/%h expected 005a/ee77", d0, d1);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d0, d1;
    logic [1:0]  pe;
    for (int a = 0; a < 8; a++) do_write(a, 2'b11, 16'(16'h1111 * a + 16'h0101));
    for (int a = 0; a < 8; a += 2) begin
      do_read(a, a + 1, d0, d1, pe);
      total++;
      if (d0 !== 16'(16'h1111 * a + 16'h0101) || d1 !== 16'(16'h1111 * (a + 1) + 16'h0101)) begin
        bad++; $display("FAIL back_to_back addr=%0d: got %h/%h expected %h/%h", a, d0, d1,
                        16'(16'h1111 * a + 16'h0101), 16'(16'h1111 * (a + 1) + 16'h0101));
      end
    end
  endtask

  task automatic test_clear;
    int cnt;
    fill_all(16'hFFFF);
    bus.r_addr = {AW'(6), AW'(7)};
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.r_data !== 32'h0) begin
      bad++; $display("FAIL clear_start: got busy=%b rdata=%h expected 1 00000000", bus.busy, bus.r_data);
    end
    bus.w_en = 1'b1; bus.w_addr = AW'(1); bus.w_be = 2'b11; bus.w_data = 16'h0033;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      bus.w_en = 1'b0;
      bus.clr  = (cnt == 3);
    end
    bus.clr = 1'b0;
    total++;
    if (cnt !== 8) begin bad++; $display("FAIL clear_busy_len: got %0d expected 8", cnt); end
    test_all_zero("clear_read");
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    fill_all(16'hFFFF);
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b1 || bus.r_data !== 32'h0) begin
      bad++; $display("FAIL midclr_reset: got busy=%b rdata=%h expected 1 00000000", bus.busy, bus.r_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_busy_low(cnt);
    total++;
    if (cnt !== 8) begin bad++; $display("FAIL midclr_busy_len: got %0d expected 8", cnt); end
    test_all_zero("midclr_read");
  endtask

`ifdef RF_PARITY_EN
  task automatic test_parity;
    logic [15:0] d0, d1;
    logic [1:0]  pe;
    do_write(4, 2'b11, 16'h0007);
    dut.r_mem[4][0] = 1'b0;
    do_read(4, 0, d0, d1, pe);
    total++;
    if (d0 !== 16'h0006 || pe !== 2'b01) begin
      bad++; $display("FAIL parity_flag: got %h perr=%b expected 0006 01", d0, pe);
    end
    do_write(4, 2'b11, 16'h0007);
    do_read(4, 0, d0, d1, pe);
    total++;
    if (d0 !== 16'h0007 || pe !== 2'b00) begin
      bad++; $display("FAIL parity_clear: got %h perr=%b expected 0007 00", d0, pe);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    reset_n    = 1'b0;
    bus.clr    = 1'b0;
    bus.w_en   = 1'b0;
    bus.w_addr = '0;
    bus.w_be   = '0;
    bus.w_data = '0;
    bus.r_addr = '0;
    test_reset();
    test_byte_enable();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
`ifdef RF_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
